// File: rtl/btt_pkg.sv
// +------------------------------------------------------------------+
// | btt_pkg : shared types and helpers for branch_target_table       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package btt_pkg;

  typedef enum logic [0:0] {
    BTT_INIT = 1'b0,
    BTT_RUN  = 1'b1
  } btt_state_t;

  function automatic int unsigned btt_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Last entry is all ones; entries 1..3 carry the legacy targets cut to pc_w.
  function automatic logic [31:0] default_target(input int unsigned idx,
                                                 input int unsigned addr_w,
                                                 input int unsigned pc_w);
    logic [31:0] mask;
    mask = (pc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pc_w) - 32'd1);
    if (idx == btt_depth(addr_w) - 1) return mask;
    case (idx)
      1:       return 32'd351 & mask;
      2:       return 32'd418 & mask;
      3:       return 32'd390 & mask;
      default: return 32'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_table_if.sv
// +------------------------------------------------------------------+
// | branch_target_table_if : lookup/write/status bundle of the table |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface branch_target_table_if #(
  parameter int ADDR_W = 3,
  parameter int PC_W   = 10,
  parameter int CNT_W  = 16
);
  logic              ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PC_W-1:0]   target;
  logic              target_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PC_W-1:0]   wr_data;
  logic              wr_ack;
  logic [CNT_W-1:0]  lookup_cnt;
  logic              parity_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  ready, target, target_valid, wr_ack, lookup_cnt, parity_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output ready, target, target_valid, wr_ack, lookup_cnt, parity_err
  );
endinterface

`default_nettype wire

// File: rtl/btt_mem.sv
// +------------------------------------------------------------------+
// | btt_mem : DEPTH x W register array, 1 write + 1 sync read port,  |
// |           write-first bypass on address collision                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module btt_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Array is deliberately unreset; the owner fills it after reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/branch_target_table.sv
// +------------------------------------------------------------------+
// | branch_target_table : writable pointer->PC table, self-init,     |
// |   registered read, bypass, saturating lookup counter.            |
// |   Optional LUT_PARITY_EN: even parity per entry, sticky error.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module branch_target_table
  import btt_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int PC_W   = 10,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  branch_target_table_if.slave bus
);

  localparam int DEPTH = btt_depth(ADDR_W);
`ifdef LUT_PARITY_EN
  localparam int MEM_W = PC_W + 1;
`else
  localparam int MEM_W = PC_W;
`endif

  logic [PC_W-1:0] w_default [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_default
      assign w_default[gi] = PC_W'(default_target(gi, ADDR_W, PC_W));
    end
  endgenerate

  btt_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt, w_init_cnt_nxt;
  logic              w_mem_we, w_mem_re;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [PC_W-1:0]   w_wdata_raw;
  logic [MEM_W-1:0]  w_mem_wdata;
  logic [MEM_W-1:0]  w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BTT_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // INIT owns the write port and blocks lookups; RUN hands both to the bus.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_mem_we       = 1'b0;
    w_mem_re       = 1'b0;
    w_mem_waddr    = bus.wr_addr;
    w_wdata_raw    = bus.wr_data;
    case (r_state)
      BTT_INIT: begin
        w_mem_we       = 1'b1;
        w_mem_waddr    = r_init_cnt;
        w_wdata_raw    = w_default[r_init_cnt];
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = BTT_RUN;
      end
      BTT_RUN: begin
        w_mem_we = bus.wr_en;
        w_mem_re = bus.rd_en;
      end
      default: w_state_nxt = BTT_INIT;
    endcase
  end

`ifdef LUT_PARITY_EN
  assign w_mem_wdata = {^w_wdata_raw, w_wdata_raw};
`else
  assign w_mem_wdata = w_wdata_raw;
`endif

  btt_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (MEM_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (w_mem_wdata),
    .re    (w_mem_re),
    .raddr (bus.rd_addr),
    .rdata (w_rd_data)
  );

  logic             r_valid;
  logic             r_wr_ack;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_wr_ack <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid  <= w_mem_re;
      r_wr_ack <= (r_state == BTT_RUN) && bus.wr_en;
      if (w_mem_re && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef LUT_PARITY_EN
  logic r_perr;
  logic w_perr_now;

  // Error shows in the same cycle as the bad data, then latches.
  assign w_perr_now = r_valid & (^w_rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perr <= 1'b0;
    else        r_perr <= r_perr | w_perr_now;
  end

  assign bus.parity_err = r_perr | w_perr_now;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.ready        = (r_state == BTT_RUN);
  assign bus.target       = w_rd_data[PC_W-1:0];
  assign bus.target_valid = r_valid;
  assign bus.wr_ack       = r_wr_ack;
  assign bus.lookup_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_table.sv
// Randomized bench for branch_target_table against an array/counter reference model;
// a second instance with a 4-bit counter exercises saturation.
`default_nettype none

module tb_branch_target_table;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_target_table_if #(.ADDR_W(3), .PC_W(10), .CNT_W(16)) bus ();
  branch_target_table_if #(.ADDR_W(3), .PC_W(10), .CNT_W(4))  bus4 ();

  branch_target_table #(.ADDR_W(3), .PC_W(10), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_target_table #(.ADDR_W(3), .PC_W(10), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: table contents, last target, counters, cycles since release.
  int unsigned c_def [8] = '{0, 351, 418, 390, 0, 0, 0, 1023};
  int unsigned m_tab [8];
  int unsigned m_target, m_valid, m_ack, m_cnt, m_cnt4, m_edges, m_perr;

  task automatic reset_model();
    for (int i = 0; i < 8; i++) m_tab[i] = c_def[i];
    m_target = 0; m_valid = 0; m_ack = 0; m_cnt = 0; m_cnt4 = 0; m_edges = 0; m_perr = 0;
  endtask

  task automatic drive(input bit re, input int unsigned ra, input bit we,
                       input int unsigned wa, input int unsigned wd);
    bus.rd_en    = re;  bus4.rd_en    = re;
    bus.rd_addr  = 3'(ra); bus4.rd_addr  = 3'(ra);
    bus.wr_en    = we;  bus4.wr_en    = we;
    bus.wr_addr  = 3'(wa); bus4.wr_addr  = 3'(wa);
    bus.wr_data  = 10'(wd); bus4.wr_data  = 10'(wd);
  endtask

  task automatic check_outputs(input string tag);
    int unsigned rdy;
    rdy = (m_edges >= 8) ? 1 : 0;
    check({tag, ".ready"},  32'(bus.ready),        rdy);
    check({tag, ".target"}, 32'(bus.target),       m_target);
    check({tag, ".valid"},  32'(bus.target_valid), m_valid);
    check({tag, ".ack"},    32'(bus.wr_ack),       m_ack);
    check({tag, ".cnt"},    32'(bus.lookup_cnt),   m_cnt);
    check({tag, ".perr"},   32'(bus.parity_err),   m_perr);
    check({tag, ".ready4"}, 32'(bus4.ready),       rdy);
    check({tag, ".target4"},32'(bus4.target),      m_target);
    check({tag, ".cnt4"},   32'(bus4.lookup_cnt),  m_cnt4);
  endtask

  // One clock: apply the rules of the table to the current inputs, then compare.
  task automatic step(input string tag);
    bit acc;
    int unsigned ra, wa, wd;
    @(posedge clk);
    acc = (m_edges >= 8);
    ra = 32'(bus.rd_addr); wa = 32'(bus.wr_addr); wd = 32'(bus.wr_data);
    m_valid = 0;
    m_ack   = 0;
    if (acc && bus.rd_en) begin
      m_target = (bus.wr_en && wa == ra) ? wd : m_tab[ra];
      m_valid  = 1;
      if (m_cnt  < 65535) m_cnt++;
      if (m_cnt4 < 15)    m_cnt4++;
    end
    if (acc && bus.wr_en) begin
      m_ack = 1;
      m_tab[wa] = wd;
    end
    if (m_edges < 1000) m_edges++;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");

    // Idle release: Ready low for 8 cycles, high on the 9th.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("init_ready_low", 32'(bus.ready), 0);
      step("init_idle");
    end
    check("ready_9th", 32'(bus.ready), 1);

    for (int a = 0; a < 8; a++) begin
      drive(1, a, 0, 0, 0);
      step("default_rd");
      check("default_const", 32'(bus.target), c_def[a]);
    end
    drive(0, 0, 0, 0, 0);
    step("idle");
    check("valid_drop", 32'(bus.target_valid), 0);

    drive(0, 0, 1, 5, 700);
    step("wr5");
    check("wr5_ack", 32'(bus.wr_ack), 1);
    drive(0, 0, 0, 0, 0);
    step("wr5_idle");
    check("wr5_ack_pulse", 32'(bus.wr_ack), 0);
    drive(1, 5, 0, 0, 0);
    step("rd5");
    check("rd5_700", 32'(bus.target), 700);

    drive(1, 2, 1, 2, 55);
    step("bypass");
    check("bypass_55", 32'(bus.target), 55);
    check("bypass_valid", 32'(bus.target_valid), 1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1023));
      step("rand");
    end

    // Activity during INIT, then a reset at INIT cycle 4 restarts the fill.
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(0, 1023));
      step("init_busy");
    end
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs("reset_mid_init");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("reinit_ready_low", 32'(bus.ready), 0);
      drive(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(0, 1023));
      step("reinit_busy");
    end
    check("reinit_cnt0", 32'(bus.lookup_cnt), 0);
    for (int a = 0; a < 8; a++) begin
      drive(1, a, 0, 0, 0);
      step("reinit_rd");
      check("reinit_default", 32'(bus.target), c_def[a]);
    end

    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom_range(0, 7), 0, 0, 0);
      step("sat_rd");
    end
    check("cnt4_sat", 32'(bus4.lookup_cnt), 15);
    check("cnt16_28", 32'(bus.lookup_cnt), 28);
    drive(0, 0, 0, 0, 0);
    step("final_idle");

`ifdef LUT_PARITY_EN
    dut.u_mem.r_mem[1][0] = ~dut.u_mem.r_mem[1][0];
    m_tab[1] = m_tab[1] ^ 1;
    drive(1, 1, 0, 0, 0);
    @(posedge clk);
    m_target = m_tab[1]; m_valid = 1; m_ack = 0; m_cnt++;
    if (m_cnt4 < 15) m_cnt4++;
    #1;
    m_perr = 1;
    check("perr_set", 32'(bus.parity_err), 1);
    check("perr_valid", 32'(bus.target_valid), 1);
    drive(0, 0, 0, 0, 0);
    check("perr4_clean", 32'(bus4.parity_err), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      m_valid = 0;
      #1;
      check("perr_sticky", 32'(bus.parity_err), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("perr_cleared", 32'(bus.parity_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
